// File: rtl/qos_port_arbiter_pkg.sv
// Shared definitions for the QoS output-port arbiter: default sizes,
// the arbiter state encoding and a helper for index widths.
package qos_port_arbiter_pkg;

  localparam int PORT_NUM_TOTAL = 16;
  localparam int PRI_NUM_TOTAL  = 8;
  localparam int PRI_W_TOTAL    = $clog2(PRI_NUM_TOTAL);

  // Width of a port index; a single-port build still needs one bit
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W_TOTAL = grant_width(PORT_NUM_TOTAL);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/qos_port_arbiter_rr_find_first.sv
// Circular find-first: returns the first set bit of vec at or after
// start, wrapping from N-1 back to 0. Purely combinational.
module qos_port_arbiter_rr_find_first #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the farthest offset down so the nearest hit is written last
  always_comb begin
    int pos;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (vec[pos]) begin
        idx   = pos[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_port_arbiter.sv
// Packet-level QoS arbiter sharing one output port among PORT_NUM queues.
// Strict priority or weighted round-robin, grant held until pkt_done.
// Optional hold watchdog enabled by defining QOS_ARB_TIMEOUT_EN.
module qos_port_arbiter
  import qos_port_arbiter_pkg::*;
#(
  parameter  int PORT_NUM       = PORT_NUM_TOTAL,
  parameter  int PRI_NUM        = PRI_NUM_TOTAL,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int PRI_W          = $clog2(PRI_NUM),
  localparam int GW             = grant_width(PORT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORT_NUM-1:0]       req,
  input  logic [PORT_NUM*PRI_W-1:0] pri,
  input  logic                      qos_mode,
  input  logic                      arb_en,
  input  logic                      pkt_done,
  output logic [GW-1:0]             grant,
  output logic                      grant_vld,
  output logic                      busy,
  output logic                      timeout_err
);

  // A credit counter holds up to PRI_NUM packets, one more than the max pri
  localparam int CW = PRI_W + 1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("qos_port_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t        state;
  logic [GW-1:0]     rr_ptr;
  logic [CW-1:0]     credit     [PORT_NUM];
  logic [CW-1:0]     credit_eff [PORT_NUM];

  logic [PRI_W-1:0]  max_pri;
  logic [PORT_NUM-1:0] strict_mask;
  logic [PORT_NUM-1:0] wrr_mask;
  logic [PORT_NUM-1:0] has_credit;
  logic [PORT_NUM-1:0] scan_vec;
  logic              need_reload;
  logic [GW-1:0]     win_idx;
  logic              win_found;
  logic [CW-1:0]     win_credit_next;
  logic [GW-1:0]     ptr_inc;

  // Strict mode candidates: requesting ports sharing the highest priority
  always_comb begin
    max_pri     = '0;
    strict_mask = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (req[i] && (pri[i*PRI_W +: PRI_W] > max_pri)) max_pri = pri[i*PRI_W +: PRI_W];
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      strict_mask[i] = req[i] && (pri[i*PRI_W +: PRI_W] == max_pri);
    end
  end

  // WRR candidates: reload every credit in the same cycle when no requester has any left
  always_comb begin
    has_credit = '0;
    wrr_mask   = '0;
    for (int i = 0; i < PORT_NUM; i++) has_credit[i] = (credit[i] != '0);
    need_reload = ~|(req & has_credit);
    for (int i = 0; i < PORT_NUM; i++) begin
      credit_eff[i] = need_reload ? (CW'(pri[i*PRI_W +: PRI_W]) + CW'(1)) : credit[i];
      wrr_mask[i]   = req[i] && (credit_eff[i] != '0);
    end
  end

  assign scan_vec = qos_mode ? wrr_mask : strict_mask;

  qos_port_arbiter_rr_find_first #(
    .N  (PORT_NUM),
    .IW (GW)
  ) u_find (
    .vec   (scan_vec),
    .start (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  assign win_credit_next = credit_eff[win_idx] - CW'(1);
  assign ptr_inc         = (win_idx == GW'(PORT_NUM - 1)) ? '0 : win_idx + GW'(1);

`ifdef QOS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] hold_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM: decide in IDLE, own the port in HOLD until the packet ends
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_vld <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      for (int i = 0; i < PORT_NUM; i++) credit[i] <= '0;
`ifdef QOS_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef QOS_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_en && win_found) begin
            grant     <= win_idx;
            grant_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_HOLD;
`ifdef QOS_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
            if (qos_mode) begin
              for (int i = 0; i < PORT_NUM; i++) begin
                credit[i] <= (GW'(i) == win_idx) ? win_credit_next : credit_eff[i];
              end
              rr_ptr <= (win_credit_next == '0) ? ptr_inc : win_idx;
            end else begin
              rr_ptr <= ptr_inc;
            end
          end
        end
        ST_HOLD: begin
          if (pkt_done) begin
            grant_vld <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
`ifdef QOS_ARB_TIMEOUT_EN
          end else if (hold_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            grant_vld   <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + TW'(1);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/qos_port_arbiter.md
Name: qos_port_arbiter

Overview:
Packet-level arbiter that shares one output port among PORT_NUM input queues.
- Each cycle it may see a request vector plus per-port priority fields.
- Mode: strict priority or weighted round-robin (WRR), selected by qos_mode.
- The grant is held for a whole packet until the output sequencer pulses pkt_done.
- Sits between the per-port descriptor registers and the output select/read sequencer.

Parameters:
PORT_NUM, 16, number of requesting input ports
PRI_NUM, 8, number of priority levels; PRI_W = clog2(PRI_NUM)
TIMEOUT_CYCLES, 4096, hold watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
req  in  PORT_NUM  per-port "packet ready" request
pri  in  PORT_NUM*PRI_W  priority of port i at bits [i*PRI_W +: PRI_W]
qos_mode  in  1  0 = strict priority, 1 = WRR
arb_en  in  1  request one arbitration decision
pkt_done  in  1  single-cycle pulse: granted packet fully sent
grant  out  max(1,clog2(PORT_NUM))  granted port index
grant_vld  out  1  grant valid; held high for the whole packet
busy  out  1  high in HOLD
timeout_err  out  1  one-cycle watchdog pulse; tied 0 without the macro

Behaviour:
- Reset state: grant=0, grant_vld=0, busy=0, timeout_err=0, all credits=0, rr_ptr=0, state=IDLE.
- Reset assertion mid-HOLD clears grant_vld immediately (asynchronous).
- States: IDLE, HOLD.
- IDLE, with arb_en=1 and |req=1 at edge N:
  - Decision is computed combinationally; grant and grant_vld are registered.
  - grant_vld=1 after edge N (1-cycle latency); busy=1; next state HOLD.
  - qos_mode and pri are sampled only at this edge.
- IDLE, with arb_en=1 and req=0: no action. pkt_done in IDLE is ignored.
- HOLD:
  - grant and grant_vld are stable; arb_en and req changes are ignored (packet ownership).
  - On pkt_done: grant_vld=0, busy=0, grant retains last value, return to IDLE.
  - arb_en in the same cycle as pkt_done is not honoured; it must be reasserted in IDLE. Minimum spacing between grants is therefore 2 cycles.
- Strict mode:
  - Winner is the requesting port with the largest pri.
  - Ties are broken by circular scan starting at rr_ptr.
  - After a grant to g: rr_ptr = (g+1) mod PORT_NUM.
  - Credits are untouched.
- WRR mode:
  - credit[i] is PRI_W+1 bits wide; its reload value is pri[i]+1 (pri=7 gives 8 packets per round).
  - Eligible port: req[i]=1 and credit[i]>0.
  - If no requesting port is eligible, all credits reload in that same decision cycle and the scan uses the reloaded values.
  - Scan is circular starting at rr_ptr (inclusive); the first eligible port wins.
  - At the decision: credit[g] decrements by 1. If the new value is 0, rr_ptr = (g+1) mod PORT_NUM; otherwise rr_ptr = g, so the port keeps its turn.
- Wrap-around: rr_ptr increments modulo PORT_NUM; for non-power-of-2 PORT_NUM it wraps from PORT_NUM-1 to 0.

Optional Feature:
QOS_ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entering HOLD and increments each HOLD cycle.
  - On reaching TIMEOUT_CYCLES-1 without pkt_done: force release (as for pkt_done) and pulse timeout_err=1 for one cycle.
  - pkt_done arriving on the same cycle as the timeout wins, and timeout_err is not pulsed.
- Undefined: no counter; timeout_err is constant 0; HOLD lasts indefinitely.

Decomposition:
- Shared package/header (generate_parameter.vh): PORT_NUB_TOTAL, PRI_NUM_TOTAL, derived PRI_W and grant width, state encodings ST_IDLE/ST_HOLD.
- Sub-module rr_find_first:
  - Inputs: PORT_NUM-bit eligible vector and start pointer.
  - Outputs: index of the first set bit at or after the pointer (circular), plus found flag.
  - Purely combinational; used by both modes (strict mode feeds it the "max-priority" mask).

Test Plan:
- Reset then strict mode, req=0x0006, pri[1]=3, pri[2]=5, arb_en pulse → grant=2, grant_vld=1 one cycle later; pkt_done → grant_vld=0 next cycle.
- Strict tie: req=0x0003, pri[0]=pri[1]=4, rr_ptr=0 → grants alternate 0,1,0,1 over four arb/pkt_done pairs.
- WRR: req=0x0003, pri[0]=2, pri[1]=0, continuous arb/done → grant sequence 0,0,0,1,0,0,0,1 (credit reload observed after each round).
- Hold integrity: during HOLD, toggle req to 0 and pulse arb_en → grant and grant_vld unchanged until pkt_done; arb_en coincident with pkt_done → no new grant that cycle.
- Reset asserted mid-HOLD → grant_vld, busy, grant go to 0 immediately; first post-reset WRR arbitration performs a credit reload.
- With QOS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no pkt_done → release at the 16th HOLD cycle with timeout_err high for exactly one cycle; without the macro, grant_vld stays high for 100+ cycles.
